// File: rtl/mux_port_arbiter.sv
// Round-robin owner of a shared 2:1 32-bit operand MUX: grants one cycle after request, holds until done/abort/MAX_HOLD.
// No backpressure path of its own; a waiting requester simply keeps its level request high until granted.
module mux_port_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic done_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic select_o,
  output logic busy_o,
  output logic timeout_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             last_owner;

  logic own_req;
  logic oth_req;
  logic at_limit;
  logic release_own;
  logic grant_vld;
  logic grant_sel;

  always_comb begin
    own_req     = (state == OWN1) ? req1_i : req0_i;
    oth_req     = (state == OWN1) ? req0_i : req1_i;
    at_limit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    release_own = 1'b0;
    grant_vld   = 1'b0;
    grant_sel   = select_o;
    case (state)
      IDLE: begin
        grant_vld = req0_i | req1_i;
        // On contention the requester that did not own last wins
        grant_sel = req1_i & (~req0_i | ~last_owner);
      end
      OWN0, OWN1: begin
        release_own = done_i | ~own_req | at_limit;
        if (oth_req) begin
          grant_vld = 1'b1;
          grant_sel = (state == OWN0);
        end else if (own_req) begin
          grant_vld = 1'b1;
          grant_sel = (state == OWN1);
        end
      end
      default: release_own = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gnt0_o     <= 1'b0;
      gnt1_o     <= 1'b0;
      select_o   <= 1'b0;
      timeout_o  <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
    end else begin
      timeout_o <= 1'b0;
      if (state == IDLE || release_own) begin
        hold_cnt <= '0;
        if (state != IDLE) begin
          last_owner <= (state == OWN1);
          // A done arriving on the limit cycle is an ordinary release
          timeout_o  <= at_limit & ~done_i & own_req;
        end
        if (grant_vld) begin
          state    <= grant_sel ? OWN1 : OWN0;
          gnt0_o   <= ~grant_sel;
          gnt1_o   <= grant_sel;
          select_o <= grant_sel;
        end else begin
          state  <= IDLE;
          gnt0_o <= 1'b0;
          gnt1_o <= 1'b0;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign busy_o = gnt0_o | gnt1_o;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Table-driven bench for mux_port_arbiter with a scoreboard queue of expected output vectors.
module tb_mux_port_arbiter;

  logic clk;
  logic rst;
  logic req0, req1, done;
  logic gnt0, gnt1, sel, busy, tmo;

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic       d;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  mux_port_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req0_i    (req0),
    .req1_i    (req1),
    .done_i    (done),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .select_o  (sel),
    .busy_o    (busy),
    .timeout_o (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {gnt0, gnt1, sel, busy, tmo};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {g0,g1,sel,busy,tmo}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, push the expectation, compare just after the edge.
  task automatic step(input string name, input logic r0, input logic r1, input logic d,
                      input logic [4:0] exp);
    sb_t e;
    req0 = r0;
    req1 = r1;
    done = d;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(e.name, outs(), e.exp);
    end
  endtask

  task automatic add(input logic r0, input logic r1, input logic d, input logic [4:0] exp);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d = d; v.exp = exp;
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if (!rst && gnt0 && gnt1) begin
      miscompares++;
      $display("FAIL mutex: gnt0=%b gnt1=%b both high, required not both", gnt0, gnt1);
    end
  end

  initial begin
    // {gnt0, gnt1, select, busy, timeout}
    add(0, 0, 0, 5'b00000);
    add(0, 0, 1, 5'b00000);  // done in IDLE ignored
    add(1, 0, 0, 5'b10010);
    add(1, 0, 0, 5'b10010);
    add(1, 0, 0, 5'b10010);
    add(0, 0, 1, 5'b00000);  // release, select stays 0
    add(1, 1, 0, 5'b01110);  // last owner 0 -> requester 1 wins
    add(1, 1, 0, 5'b01110);
    add(1, 1, 1, 5'b10010);  // switch, no bubble
    add(1, 1, 0, 5'b10010);
    add(1, 1, 0, 5'b10010);
    add(1, 1, 1, 5'b01110);
    add(1, 1, 0, 5'b01110);
    add(1, 1, 0, 5'b01110);
    add(1, 1, 1, 5'b10010);
    add(0, 1, 0, 5'b01110);  // abort by owner 0 hands over to 1
    add(0, 0, 0, 5'b00100);  // IDLE, select holds 1
    add(0, 0, 1, 5'b00100);
    add(1, 0, 1, 5'b10010);  // done with request in IDLE still grants
    add(1, 0, 1, 5'b10010);  // done with req still high re-grants
    add(0, 0, 0, 5'b00000);

    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    done = 1'b0;
    #12;
    check("reset_state", outs(), 5'b00000);
    rst = 1'b0;

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].d, vecs[i].exp);

    // Requester 1 alone: forced release after 16 held cycles, re-grant, then again
    for (int i = 0; i <= 32; i++)
      step($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, {4'b0111, (i == 16 || i == 32)});
    step("hold_drop", 1'b0, 1'b0, 1'b0, 5'b00100);

    // done lands exactly on the limit cycle with requester 1 waiting
    step("lim_enter", 1'b1, 1'b0, 1'b0, 5'b10010);
    for (int i = 1; i <= 15; i++)
      step($sformatf("lim_hold%0d", i), 1'b1, 1'b1, 1'b0, 5'b10010);
    step("lim_done", 1'b1, 1'b1, 1'b1, 5'b01110);
    step("lim_after", 1'b1, 1'b1, 1'b0, 5'b01110);
    for (int i = 2; i <= 7; i++)
      step($sformatf("own1_cnt%0d", i), 1'b0, 1'b1, 1'b0, 5'b01110);

    // Asynchronous reset mid-cycle while OWN1 with counter at 7
    #2 rst = 1'b1;
    #1 check("async_rst", outs(), 5'b00000);
    #2 rst = 1'b0;
    step("post_rst_both", 1'b1, 1'b1, 1'b0, 5'b10010);
    step("post_rst_abort", 1'b0, 1'b0, 1'b0, 5'b00000);
    step("idle_done", 1'b0, 1'b0, 1'b1, 5'b00000);
    step("idle_quiet", 1'b0, 1'b0, 1'b0, 5'b00000);

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
